jam_search_param: RTL and testbench

//  Exhaustive job-assignment search: N workers x N jobs, all N! permutations visited in

---
 rtl/jam_search_param.sv | 175 +++++++++++++++++
 tb/tb_jam_search_param.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/jam_search_param.sv
// Exhaustive N x N job-assignment search: walks all N! permutations in lexicographic
// order and reports the best (min or max) total cost, its multiplicity and first permutation.
module jam_search_param #(
   parameter  int N   = 8,
   parameter  int CW  = 7,
   parameter  int MCW = 16,
   localparam int IW  = $clog2(N),
   localparam int SW  = CW + $clog2(N)
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            START,
   input  logic            MODE,
   output logic            BUSY,
   output logic [IW-1:0]   W,
   output logic [IW-1:0]   J,
   input  logic [CW-1:0]   Cost,
   output logic [SW-1:0]   MinCost,
   output logic [MCW-1:0]  MatchCount,
   output logic [N*IW-1:0] BestPerm,
   output logic            Valid
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CMP, S_PIVOT, S_SUCC, S_SWAP, S_REV, S_DONE
   } state_t;

   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t          state_q, state_d;
   logic [IW-1:0]   perm_q [N];
   logic [IW-1:0]   perm_d [N];
   logic [IW-1:0]   best_q [N];
   logic [IW-1:0]   best_d [N];
   logic [SW-1:0]   acc_q, acc_d;
   logic [SW-1:0]   min_q, min_d;
   logic [MCW-1:0]  cnt_q, cnt_d;
   logic [IW-1:0]   w_q, w_d;
   logic [IW-1:0]   piv_q, piv_d;
   logic [IW-1:0]   succ_q, succ_d;
   logic [IW-1:0]   lo_q, lo_d;
   logic [IW-1:0]   hi_q, hi_d;
   logic            mode_q, mode_d;
   logic            better, equal;

   assign better = mode_q ? (acc_q > min_q) : (acc_q < min_q);
   assign equal  = (acc_q == min_q);

   always_comb begin
      // NOTE: every next-state signal takes its current value first, so no path infers a latch.
      state_d = state_q;
      perm_d  = perm_q;
      best_d  = best_q;
      acc_d   = acc_q;
      min_d   = min_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      piv_d   = piv_q;
      succ_d  = succ_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      mode_d  = mode_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (START) begin
               for (int x = 0; x < N; x++) perm_d[x] = IW'(x);
               acc_d   = '0;
               w_d     = '0;
               min_d   = MODE ? '0 : '1;
               cnt_d   = '0;
               mode_d  = MODE;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            acc_d = acc_q + SW'(Cost);
            if (w_q == LAST) state_d = S_CMP;
            else             w_d     = w_q + 1'b1;
         end
         S_CMP: begin
            if (better) begin
               min_d  = acc_q;
               cnt_d  = MCW'(1);
               best_d = perm_q;
            end else if (equal && (cnt_q != '1)) begin
               cnt_d = cnt_q + 1'b1;
            end
            piv_d   = IW'(N - 2);
            state_d = S_PIVOT;
         end
         S_PIVOT: begin
            if (perm_q[piv_q] < perm_q[piv_q + 1'b1]) begin
               succ_d  = LAST;
               state_d = S_SUCC;
            end else if (piv_q == '0) begin
               state_d = S_DONE;
            end else begin
               piv_d = piv_q - 1'b1;
            end
         end
         S_SUCC: begin
            // A pivot exists, so some element right of it is larger; the scan always terminates.
            if (perm_q[succ_q] > perm_q[piv_q]) state_d = S_SWAP;
            else                                succ_d  = succ_q - 1'b1;
         end
         S_SWAP: begin
            perm_d[piv_q]  = perm_q[succ_q];
            perm_d[succ_q] = perm_q[piv_q];
            lo_d    = piv_q + 1'b1;
            hi_d    = LAST;
            state_d = S_REV;
         end
         S_REV: begin
            if (lo_q < hi_q) begin
               perm_d[lo_q] = perm_q[hi_q];
               perm_d[hi_q] = perm_q[lo_q];
               lo_d = lo_q + 1'b1;
               hi_d = hi_q - 1'b1;
            end else begin
               acc_d   = '0;
               w_d     = '0;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         // NOTE: the permutation registers are reset to identity because J reads them directly.
         state_q <= S_IDLE;
         for (int x = 0; x < N; x++) begin
            perm_q[x] <= IW'(x);
            best_q[x] <= IW'(x);
         end
         acc_q  <= '0;
         min_q  <= '1;
         cnt_q  <= '0;
         w_q    <= '0;
         piv_q  <= '0;
         succ_q <= '0;
         lo_q   <= '0;
         hi_q   <= '0;
         mode_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
         state_q <= state_d;
         perm_q  <= perm_d;
         best_q  <= best_d;
         acc_q   <= acc_d;
         min_q   <= min_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         piv_q   <= piv_d;
         succ_q  <= succ_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         mode_q  <= mode_d;
      end
   end

   assign W          = w_q;
   assign J          = perm_q[w_q];
   assign MinCost    = min_q;
   assign MatchCount = cnt_q;
   assign Valid      = (state_q == S_DONE);
   assign BUSY       = (state_q != S_DONE) && (state_q != S_IDLE);

   for (genvar g = 0; g < N; g++) begin : g_best
      assign BestPerm[g*IW +: IW] = best_q[g];
   end

endmodule

// File: tb/tb_jam_search_param.sv
// Directed bench for jam_search_param at N=4, CW=4, MCW=4 (count saturates at 15).
module tb_jam_search_param;

   localparam int N   = 4;
   localparam int CW  = 4;
   localparam int MCW = 4;
   localparam int IW  = 2;
   localparam int SW  = 6;

   logic            CLK, RST_N, START, MODE;
   logic            BUSY, Valid;
   logic [IW-1:0]   W, J;
   logic [CW-1:0]   Cost;
   logic [SW-1:0]   MinCost;
   logic [MCW-1:0]  MatchCount;
   logic [N*IW-1:0] BestPerm;

   logic [CW-1:0] mat [N][N];
   int            tbl [N][N] = '{'{5, 1, 9, 15}, '{2, 8, 3, 15}, '{7, 6, 4, 15}, '{15, 15, 15, 0}};
   int            n_checks = 0;
   int            n_pass   = 0;

   jam_search_param #(.N(N), .CW(CW), .MCW(MCW)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE), .BUSY(BUSY),
      .W(W), .J(J), .Cost(Cost), .MinCost(MinCost), .MatchCount(MatchCount),
      .BestPerm(BestPerm), .Valid(Valid)
   );

   assign Cost = mat[W][J];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // 0 zero, 1 diag-free, 2 cost=j, 3 anti-diagonal 15, 4 diagonal 1, 5 embedded 3x3 table
   task automatic set_mat(input int kind);
      int v;
      for (int w = 0; w < N; w++) begin
         for (int j = 0; j < N; j++) begin
            case (kind)
               1:       v = (w == j) ? 0 : 1;
               2:       v = j;
               3:       v = (j == N - 1 - w) ? 15 : 0;
               4:       v = (w == j) ? 1 : 0;
               5:       v = tbl[w][j];
               default: v = 0;
            endcase
            mat[w][j] = CW'(v);
         end
      end
   endtask

   task automatic run(input string tag, input logic m, input bit interfere,
                      input int exp_cost, input int exp_cnt, input int exp_perm);
      START = 1'b1;
      MODE  = m;
      @(negedge CLK);
      START = 1'b0;
      check({tag, "_busy_on_start"}, 32'(BUSY), 1);
      check({tag, "_valid_drop"}, 32'(Valid), 0);
      check({tag, "_init_best"}, 32'(MinCost), m ? 0 : 63);
      check({tag, "_init_count"}, 32'(MatchCount), 0);
      for (int c = 0; c < 2000 && !Valid; c++) begin
         if (interfere && c == 10) begin
            START = 1'b1;
            MODE  = ~m;
         end else begin
            START = 1'b0;
         end
         @(negedge CLK);
      end
      START = 1'b0;
      check({tag, "_valid"}, 32'(Valid), 1);
      check({tag, "_busy_done"}, 32'(BUSY), 0);
      check({tag, "_best"}, 32'(MinCost), 32'(exp_cost));
      check({tag, "_count"}, 32'(MatchCount), 32'(exp_cnt));
      check({tag, "_perm"}, 32'(BestPerm), 32'(exp_perm));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, 32'(BUSY), 0);
      check({tag, "_valid"}, 32'(Valid), 0);
      check({tag, "_w"}, 32'(W), 0);
      check({tag, "_j"}, 32'(J), 0);
      check({tag, "_best"}, 32'(MinCost), 63);
      check({tag, "_count"}, 32'(MatchCount), 0);
      check({tag, "_perm"}, 32'(BestPerm), 'hE4);
   endtask

   initial begin
      RST_N = 1'b0;
      START = 1'b0;
      MODE  = 1'b0;
      set_mat(0);
      #23;
      check_reset_state("reset");
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      set_mat(0); run("zero_min",    1'b0, 1'b0, 0,  15, 'hE4);
      set_mat(1); run("diag_min",    1'b0, 1'b0, 0,  1,  'hE4);
      set_mat(2); run("colj_min",    1'b0, 1'b0, 6,  15, 'hE4);
      set_mat(2); run("colj_max",    1'b1, 1'b0, 6,  15, 'hE4);
      set_mat(3); run("anti_max",    1'b1, 1'b0, 60, 1,  'h1B);
      set_mat(4); run("derange_min", 1'b0, 1'b0, 0,  9,  'hB1);
      set_mat(4); run("derange_max", 1'b1, 1'b0, 4,  1,  'hE4);
      set_mat(5); run("tbl_min",     1'b0, 1'b0, 7,  1,  'hE1);
      set_mat(5); run("tbl_max",     1'b1, 1'b0, 47, 1,  'h36);
      set_mat(5); run("tbl_restart", 1'b0, 1'b1, 7,  1,  'hE1);

      // Abort mid-FETCH: W has advanced to 2 when reset hits.
      START = 1'b1;
      MODE  = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("mid_fetch_w", 32'(W), 2);
      RST_N = 1'b0;
      #1;
      check_reset_state("abort");
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      check("abort_idle_busy", 32'(BUSY), 0);

      set_mat(5); run("after_abort", 1'b1, 1'b0, 47, 1, 'h36);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
